// File: rtl/recv_frame.sv
// recv_frame: 8N1 UART receiver that assembles NBYTES bytes into one word.
// The first byte received lands in the least-significant byte of Data_out.
// Partial frames are dropped on a bad stop bit or on an over-long gap between bytes.
module recv_frame #(
  parameter int NBYTES       = 5,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [2:0]            time_set,
  input  logic                  uart_rx,
  output logic [8*NBYTES-1:0]   Data_out,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int CW = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Clocks per bit for each baud select; the unused codes fall back to 115200.
  function automatic logic [12:0] baud_div(input logic [2:0] ts);
    case (ts)
      3'd0:    baud_div = 13'd5208;
      3'd1:    baud_div = 13'd2604;
      3'd2:    baud_div = 13'd1302;
      3'd3:    baud_div = 13'd868;
      default: baud_div = 13'd434;
    endcase
  endfunction

  state_t               rx_state;
  logic                 rx_p0, rx_p1, rx_p2;
  logic [12:0]          div;
  logic [12:0]          bit_cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shreg;
  logic [8*NBYTES-1:0]  frame;
  logic [CW-1:0]        byte_cnt;
  logic [16:0]          gap;
  logic [16:0]          gap_lim;
  logic                 frame_done;
  logic                 fall;
  logic                 gap_hit;
  logic [12:0]          half_term;
  logic [12:0]          bit_term;

  assign fall      = ~rx_p1 & rx_p2;
  assign half_term = (div >> 1) - 13'd1;
  assign bit_term  = div - 13'd1;
  assign gap_lim   = 17'(TIMEOUT_BITS * int'(div));
  assign gap_hit   = (rx_state == IDLE) && (byte_cnt != '0) && (gap == gap_lim - 17'd1);
  assign rx_busy   = (rx_state != IDLE) || (byte_cnt != '0);

  // Two-flop synchroniser followed by one delay flop for falling-edge detection.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= uart_rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  // Byte state machine, frame assembly, inter-byte timeout and output pulses.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rx_state    <= IDLE;
      div         <= 13'd434;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame       <= '0;
      byte_cnt    <= '0;
      gap         <= '0;
      frame_done  <= 1'b0;
      Data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      // --- frame publish stage: one clock after the last stop-bit sample
      if (frame_done) begin
        Data_out    <= frame;
        frame_valid <= 1'b1;
        frame_done  <= 1'b0;
      end

      // Gap counter only runs while idling inside a partial frame.
      if (rx_state != IDLE || byte_cnt == '0 || fall)
        gap <= '0;
      else
        gap <= gap + 17'd1;

      // Timeout is handled even if a start edge arrives the same cycle;
      // that new byte then becomes byte 0 of a fresh frame.
      if (gap_hit) begin
        byte_cnt  <= '0;
        frame_err <= 1'b1;
      end

      case (rx_state)
        IDLE: begin
          if (fall) begin
            rx_state <= START;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            div      <= baud_div(time_set);
          end
        end
        START: begin
          if (bit_cnt >= half_term) begin
            bit_cnt  <= '0;
            rx_state <= rx_p1 ? IDLE : DATA;
          end else begin
            bit_cnt <= bit_cnt + 13'd1;
          end
        end
        DATA: begin
          if (bit_cnt >= bit_term) begin
            bit_cnt <= '0;
            shreg   <= {rx_p1, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              rx_state <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 13'd1;
          end
        end
        STOP: begin
          if (bit_cnt >= bit_term) begin
            bit_cnt  <= '0;
            rx_state <= IDLE;
            if (rx_p1) begin
              frame <= {shreg, frame[8*NBYTES-1:8]};
              if (byte_cnt == CW'(NBYTES - 1)) begin
                byte_cnt   <= '0;
                frame_done <= 1'b1;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end else begin
              byte_cnt  <= '0;
              frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 13'd1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/recv_frame.md
Name: recv_frame

Overview:
- UART frame receiver: the receiving end of the 5-byte frame link driven by the team's multi-byte UART transmitter.
- Deserialises 8N1 bytes from uart_rx and assembles NBYTES bytes into one word.
- Byte k lands at Data_out[8k+7:8k]; the first byte received is the least-significant byte, matching transmitter order.
- Pulses frame_valid on a complete frame; flags framing errors and inter-byte timeouts.

Parameters:
- NBYTES, 5, bytes per frame; Data_out width = 8*NBYTES.
- TIMEOUT_BITS, 20, maximum idle gap between bytes of one frame, in bit times.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- time_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; values 5-7 are treated as 4.
- uart_rx  input  1  asynchronous serial line, idle high.
- Data_out  output  8*NBYTES  last complete frame.
- frame_valid  output  1  one-cycle pulse when Data_out updates.
- frame_err  output  1  one-cycle pulse when a partial frame is discarded.
- rx_busy  output  1  high when rx_state != IDLE or byte_cnt != 0.

Behaviour:
- Reset: when rst is high at a sys_clk edge, all state is cleared. Data_out=0, frame_valid=0, frame_err=0, rx_busy=0, byte_cnt=0, rx_state=IDLE. The synchroniser flops reset to 1. A reset mid-frame drops the partial frame with no frame_err pulse.
- Input synchroniser:
  - uart_rx passes through a 2-flop synchroniser, then a 1-flop delay used for edge detection.
  - A falling edge is sync=0 and delayed=1.
- Baud divisor DIV (clocks per bit): 5208, 2604, 1302, 868, 434 for time_set 0..4.
  - DIV is latched on start-bit detection and held for the whole byte.
  - A change of time_set mid-byte has no effect until the next start bit.
- Byte state machine (rx_state):
  - IDLE: a falling edge moves to START and clears the bit counter.
  - START: count DIV/2 clocks, then sample the line. Low goes to DATA. High is a glitch: return to IDLE with no error and byte_cnt unchanged.
  - DATA: sample every DIV clocks, 8 samples, LSB first, shifted right into an 8-bit register. After the 8th sample go to STOP.
  - STOP: sample after DIV clocks (mid stop bit), then return to IDLE in the same transition, so back-to-back bytes are accepted.
    - Stop bit high: byte accepted.
    - Stop bit low: framing error. Discard the partial frame, set byte_cnt=0, pulse frame_err.
- Frame assembly:
  - An accepted byte is shifted into a frame register: frame <= {byte, frame[8*NBYTES-1:8]}. byte_cnt increments.
  - When the accepted byte makes byte_cnt reach NBYTES:
    - On the next clock Data_out <= frame and frame_valid=1 for exactly one cycle.
    - byte_cnt returns to 0.
  - Data_out holds its value until the next complete frame. Errors never modify Data_out.
- Inter-byte timeout:
  - While rx_state=IDLE and byte_cnt != 0, a gap counter counts clocks. It is cleared on every falling edge and whenever byte_cnt=0.
  - When it reaches TIMEOUT_BITS*DIV: discard the partial frame, set byte_cnt=0, pulse frame_err.
  - If timeout and a falling edge occur in the same cycle, the timeout is processed and the falling edge still starts a new byte, which becomes byte 0 of a new frame.
- frame_valid and frame_err are never high in the same cycle. Each is exactly one cycle wide per event.
- Latency: frame_valid rises 1 clock after the stop-bit sample of byte NBYTES-1.
- Counters:
  - Bit-time counter is 13 bits wide and saturates at its terminal value before reload.
  - Gap counter is 17 bits wide (20*5208 = 104160 fits).

Test Plan:
- time_set=2; send bytes 0x11,0x22,0x33,0x44,0x55 back-to-back -> Data_out=0x5544332211, one frame_valid pulse, frame_err stays 0.
- Reset: hold rst 3 cycles -> all outputs 0. Then release with uart_rx high for 10 bit times -> no activity, rx_busy=0.
- time_set=4; 3 bytes, then stop bit of byte 4 driven low -> frame_err pulses once, Data_out unchanged. A following full 5-byte frame 0xA0..0xA4 -> Data_out=0xA4A3A2A1A0.
- time_set=0; 2 bytes, then line idle 25 bit times -> frame_err pulses once, at TIMEOUT_BITS*5208 clocks after the end of byte 2. Next 5 bytes form a correct frame.
- 1-bit-time/4 low glitch on idle line (time_set=1) -> no byte accepted, no frame_err, byte_cnt unchanged.
- Change time_set 2->4 mid-byte -> that byte is still received correctly at 38400. The next byte, sent at 115200, is also received correctly.
